sa_feed_ctrl: RTL and testbench

- Sequencer for the N x N systolic multiply array. It holds one A matrix and one B matrix in local operand buffers and clears the array's accumulators.
- It then streams A rows (west edge) and B columns (north edge) with the diagonal skew the array needs, waits for the last partial product to land, and signals result-valid.
- Sits between the host or load path and the array's A0..A(N-1), B0..B(N-1) and active-high clear inputs.

---
 rtl/sa_feed_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_sa_feed_ctrl.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sa_feed_ctrl.sv
// sa_feed_ctrl: operand buffers and sequencer for an N x N systolic multiply
// array. Holds one A and one B matrix and clears the array accumulators. It
// then streams skewed A rows (west edge) and B columns (north edge), waits
// for the last partial product to land, and flags the result valid.
module sa_feed_ctrl #(
    parameter int N      = 8,
    parameter int WIDTH  = 8,
    parameter int PE_LAT = 1,
    localparam int IW    = (N > 1) ? $clog2(N) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_ld_en,
    input  logic                 i_ld_sel,
    input  logic [IW-1:0]        i_ld_row,
    input  logic [IW-1:0]        i_ld_col,
    input  logic [WIDTH-1:0]     i_ld_data,
    output logic                 o_ld_rej,
    input  logic                 i_start,
    input  logic                 i_res_ack,
    output logic                 o_busy,
    output logic                 o_res_valid,
    output logic                 o_sa_clr,
    output logic [N*WIDTH-1:0]   o_a_feed,
    output logic [N*WIDTH-1:0]   o_b_feed
);

    // Step counter spans the longest phase (FEED runs 3N-2 steps).
    localparam int SW = $clog2(3 * N);
    localparam logic [SW-1:0] LAST_T     = SW'(3 * N - 3);
    localparam logic [SW-1:0] DRAIN_LAST = SW'(PE_LAT - 1);
    localparam logic [SW-1:0] N_STEP     = SW'(N);
    localparam logic [IW:0]   N_IDX      = (IW + 1)'(N);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_FEED  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [SW-1:0]       r_step;
    logic [SW-1:0]       w_step_next;

    logic [WIDTH-1:0]    r_buf_a [N][N];
    logic [WIDTH-1:0]    r_buf_b [N][N];

    logic                w_locked;
    logic                w_in_range;
    logic                w_wr_en;
    logic                w_rej;
    logic                w_feed_next;
    logic [N*WIDTH-1:0]  w_a_next;
    logic [N*WIDTH-1:0]  w_b_next;

    logic                r_ld_rej;
    logic                r_busy;
    logic                r_res_valid;
    logic                r_sa_clr;
    logic [N*WIDTH-1:0]  r_a_feed;
    logic [N*WIDTH-1:0]  r_b_feed;

    // Buffers are frozen while the array is being cleared, fed or drained.
    assign w_locked    = (r_state == S_CLEAR) || (r_state == S_FEED) || (r_state == S_DRAIN);
    // Only matters when N is not a power of two.
    assign w_in_range  = ({1'b0, i_ld_row} < N_IDX) && ({1'b0, i_ld_col} < N_IDX);
    assign w_wr_en     = i_ld_en && !w_locked && w_in_range;
    assign w_rej       = i_ld_en && !w_wr_en;
    assign w_feed_next = (w_state_next == S_FEED);

    // State and step registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_step  <= '0;
        end else begin
            r_state <= w_state_next;
            r_step  <= w_step_next;
        end
    end

    // Next-state and next-step logic; step restarts at 0 on every phase change.
    always_comb begin
        w_state_next = r_state;
        w_step_next  = '0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_next = S_CLEAR;
                end
            end
            S_CLEAR: begin
                w_state_next = S_FEED;
            end
            S_FEED: begin
                if (r_step == LAST_T) begin
                    w_state_next = S_DRAIN;
                end else begin
                    w_step_next = r_step + SW'(1);
                end
            end
            S_DRAIN: begin
                if (r_step == DRAIN_LAST) begin
                    w_state_next = S_DONE;
                end else begin
                    w_step_next = r_step + SW'(1);
                end
            end
            S_DONE: begin
                // A new start doubles as the acknowledge.
                if (i_start) begin
                    w_state_next = S_CLEAR;
                end else if (i_res_ack) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Operand buffer writes; a write coinciding with start lands before step 0 is read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    r_buf_a[r][c] <= '0;
                    r_buf_b[r][c] <= '0;
                end
            end
        end else if (w_wr_en) begin
            if (i_ld_sel) begin
                r_buf_b[i_ld_row][i_ld_col] <= i_ld_data;
            end else begin
                r_buf_a[i_ld_row][i_ld_col] <= i_ld_data;
            end
        end
    end

    // Skewed feed selection for the upcoming step: row i carries A[i][t-i],
    // column j carries B[t-j][j], zero outside the diagonal band.
    for (genvar gi = 0; gi < N; gi++) begin : g_feed
        logic [SW-1:0] w_ka;
        logic [SW-1:0] w_kb;

        assign w_ka = w_step_next - SW'(gi);
        assign w_kb = w_step_next - SW'(gi);

        assign w_a_next[gi*WIDTH +: WIDTH] =
            (w_feed_next && (w_step_next >= SW'(gi)) && (w_ka < N_STEP))
                ? r_buf_a[gi][w_ka[IW-1:0]] : '0;
        assign w_b_next[gi*WIDTH +: WIDTH] =
            (w_feed_next && (w_step_next >= SW'(gi)) && (w_kb < N_STEP))
                ? r_buf_b[w_kb[IW-1:0]][gi] : '0;
    end

    // Output registers, all derived from the next state so they align with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ld_rej    <= 1'b0;
            r_busy      <= 1'b0;
            r_res_valid <= 1'b0;
            r_sa_clr    <= 1'b0;
            r_a_feed    <= '0;
            r_b_feed    <= '0;
        end else begin
            r_ld_rej    <= w_rej;
            r_busy      <= (w_state_next == S_CLEAR) || (w_state_next == S_FEED)
                           || (w_state_next == S_DRAIN);
            r_res_valid <= (w_state_next == S_DONE);
            r_sa_clr    <= (w_state_next == S_CLEAR);
            r_a_feed    <= w_a_next;
            r_b_feed    <= w_b_next;
        end
    end

    assign o_ld_rej    = r_ld_rej;
    assign o_busy      = r_busy;
    assign o_res_valid = r_res_valid;
    assign o_sa_clr    = r_sa_clr;
    assign o_a_feed    = r_a_feed;
    assign o_b_feed    = r_b_feed;

endmodule

// File: tb/tb_sa_feed_ctrl.sv
// Self-checking bench for sa_feed_ctrl. A timeline model (edges since start)
// predicts every output each cycle; the captured feed streams are folded
// through an ideal systolic array to check the resulting product.
module tb_sa_feed_ctrl;

    localparam int N        = 8;
    localparam int W        = 8;
    localparam int PE_LAT   = 1;
    localparam int NSTEP    = 3 * N - 2;
    localparam int BUSY_LEN = 3 * N - 1 + PE_LAT;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             ld_en = 1'b0;
    logic             ld_sel = 1'b0;
    logic [2:0]       ld_row = '0;
    logic [2:0]       ld_col = '0;
    logic [W-1:0]     ld_data = '0;
    logic             start = 1'b0;
    logic             res_ack = 1'b0;
    logic             ld_rej;
    logic             busy;
    logic             res_valid;
    logic             sa_clr;
    logic [N*W-1:0]   a_feed;
    logic [N*W-1:0]   b_feed;

    always #5 clk = ~clk;

    sa_feed_ctrl #(.N(N), .WIDTH(W), .PE_LAT(PE_LAT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_ld_en    (ld_en),
        .i_ld_sel   (ld_sel),
        .i_ld_row   (ld_row),
        .i_ld_col   (ld_col),
        .i_ld_data  (ld_data),
        .o_ld_rej   (ld_rej),
        .i_start    (start),
        .i_res_ack  (res_ack),
        .o_busy     (busy),
        .o_res_valid(res_valid),
        .o_sa_clr   (sa_clr),
        .o_a_feed   (a_feed),
        .o_b_feed   (b_feed)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model state
    int mA [N][N];
    int mB [N][N];
    bit m_busy = 1'b0;
    bit m_done = 1'b0;
    bit m_rej  = 1'b0;
    int m_d    = 0;
    int hist_a [NSTEP][N];
    int hist_b [NSTEP][N];
    int c_dut  [N][N];

    // Model: m_d counts edges since the start edge; operation lasts BUSY_LEN edges.
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            for (int r = 0; r < N; r++)
                for (int c = 0; c < N; c++) begin
                    mA[r][c] = 0;
                    mB[r][c] = 0;
                end
            m_busy = 1'b0;
            m_done = 1'b0;
            m_rej  = 1'b0;
            m_d    = 0;
        end else begin
            m_rej = ld_en && m_busy;
            if (ld_en && !m_busy) begin
                if (ld_sel) mB[ld_row][ld_col] = int'(ld_data);
                else        mA[ld_row][ld_col] = int'(ld_data);
            end
            if (m_busy) begin
                m_d = m_d + 1;
                if (m_d == BUSY_LEN) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                end
            end else if (start) begin
                m_busy = 1'b1;
                m_d    = 0;
                m_done = 1'b0;
            end else if (m_done && res_ack) begin
                m_done = 1'b0;
            end
        end
    end

    function automatic logic [N*W-1:0] exp_feed(input bit is_b);
        logic [N*W-1:0] v;
        int t, k;
        v = '0;
        if (m_busy && m_d >= 1 && m_d <= NSTEP) begin
            t = m_d - 1;
            for (int i = 0; i < N; i++) begin
                k = t - i;
                if (k >= 0 && k < N)
                    v[i*W +: W] = is_b ? W'(mB[k][i]) : W'(mA[i][k]);
            end
        end
        return v;
    endfunction

    task automatic check_eq(input string name, input int got, input int exp_v);
        n_tests++;
        if (got != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp_v, $time);
        end
    endtask

    task automatic check_vec(input string name, input logic [N*W-1:0] got, input logic [N*W-1:0] exp_v);
        n_tests++;
        if (got !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp_v, $time);
        end
    endtask

    // Per-cycle compare against the model, plus feed capture.
    initial forever begin
        @(negedge clk);
        check_eq("busy", int'(busy), int'(m_busy));
        check_eq("res_valid", int'(res_valid), int'(m_done));
        check_eq("sa_clr", int'(sa_clr), int'(m_busy && m_d == 0));
        check_eq("ld_rej", int'(ld_rej), int'(m_rej));
        check_vec("a_feed", a_feed, exp_feed(1'b0));
        check_vec("b_feed", b_feed, exp_feed(1'b1));
        if (m_busy && m_d == 0) begin
            for (int s = 0; s < NSTEP; s++)
                for (int i = 0; i < N; i++) begin
                    hist_a[s][i] = 0;
                    hist_b[s][i] = 0;
                end
        end
        if (m_busy && m_d >= 1 && m_d <= NSTEP) begin
            for (int i = 0; i < N; i++) begin
                hist_a[m_d-1][i] = int'(a_feed[i*W +: W]);
                hist_b[m_d-1][i] = int'(b_feed[i*W +: W]);
            end
        end
    end

    // Fold the captured streams through an ideal array and compare with A x B.
    task automatic check_product(input string name);
        int u, acc, expv, bad;
        bad = 0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                acc = 0;
                for (int s = 0; s < NSTEP; s++) begin
                    u = s + j - i;
                    if (u >= 0 && u < NSTEP) acc += hist_a[s][i] * hist_b[u][j];
                end
                c_dut[i][j] = acc;
                expv = 0;
                for (int k = 0; k < N; k++) expv += mA[i][k] * mB[k][j];
                if (acc != expv && bad == 0)
                    $display("FAIL %s_product: C[%0d][%0d] got %0d expected %0d", name, i, j, acc, expv);
                if (acc != expv) bad++;
            end
        n_tests++;
        if (bad != 0) n_fail++;
        $display("[TB] %s: product checked, %0d wrong elements", name, bad);
    endtask

    task automatic ld(input bit sel, input int r, input int c, input int d);
        ld_en   = 1'b1;
        ld_sel  = sel;
        ld_row  = 3'(r);
        ld_col  = 3'(c);
        ld_data = W'(d);
        @(negedge clk);
        ld_en   = 1'b0;
    endtask

    task automatic go();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic ack();
        res_ack = 1'b1;
        @(negedge clk);
        res_ack = 1'b0;
    endtask

    task automatic wait_done(output int nb, output int nc);
        nb = 0;
        nc = 0;
        for (int i = 0; i < 200 && !res_valid; i++) begin
            nb += int'(busy);
            nc += int'(sa_clr);
            @(negedge clk);
        end
        check_eq("done_reached", int'(res_valid), 1);
    endtask

    task automatic wait_step(input int d);
        for (int i = 0; i < 100 && m_d != d; i++) @(negedge clk);
        check_eq("step_reached", m_d, d);
    endtask

    initial begin
        int nb, nc, bad, rej_cnt;
        logic [N*W-1:0] skew_exp;

        // Reset with random inputs
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            ld_en   = 1'($urandom_range(0, 1));
            ld_sel  = 1'($urandom_range(0, 1));
            ld_row  = 3'($urandom_range(0, 7));
            ld_col  = 3'($urandom_range(0, 7));
            ld_data = W'($urandom);
            start   = 1'($urandom_range(0, 1));
            res_ack = 1'($urandom_range(0, 1));
            #1;
            check_eq("rst_outputs", int'({ld_rej, busy, res_valid, sa_clr}), 0);
            check_vec("rst_feeds", a_feed | b_feed, '0);
        end
        @(negedge clk);
        ld_en = 1'b0; start = 1'b0; res_ack = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        $display("[TB] reset/idle outputs checked");

        // Zero product with empty buffers
        go();
        wait_done(nb, nc);
        check_eq("zero_busy_len", nb, BUSY_LEN);
        check_product("zero");
        bad = 0;
        for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) if (c_dut[i][j] != 0) bad++;
        check_eq("zero_c_literal", bad, 0);
        ack();

        // Identity product
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                ld(1'b0, r, c, (r == c) ? 1 : 0);
                ld(1'b1, r, c, 8 * r + c);
            end
        go();
        wait_done(nb, nc);
        check_eq("ident_busy_len", nb, 24);
        check_eq("ident_clr_pulses", nc, 1);
        check_product("ident");
        bad = 0;
        for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) if (c_dut[i][j] != 8 * i + j) bad++;
        check_eq("ident_c_literal", bad, 0);
        check_eq("ident_c77", c_dut[7][7], 63);
        ack();

        // Skew check
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                ld(1'b0, r, c, 16 * r + c);
                ld(1'b1, r, c, 1);
            end
        go();
        wait_step(4);
        skew_exp = 64'h00000000_30211203;
        check_vec("skew_t3_a_feed", a_feed, skew_exp);
        wait_done(nb, nc);
        check_product("skew");
        ack();
        $display("[TB] skew step 3 checked");

        // Locked loads during FEED, plus an ignored start
        go();
        wait_step(3);
        rej_cnt = 0;
        ld_en = 1'b1; ld_sel = 1'b0; ld_row = 3'd0; ld_col = 3'd0; ld_data = 8'hFF;
        repeat (3) begin
            @(negedge clk);
            rej_cnt += int'(ld_rej);
        end
        ld_en = 1'b0;
        check_eq("locked_rej_count", rej_cnt, 3);
        wait_step(9);
        go();
        wait_done(nb, nc);
        check_product("locked");
        check_eq("locked_c00", c_dut[0][0], 28);
        // Load in DONE keeps res_valid
        ld(1'b0, 0, 0, 5);
        check_eq("done_load_valid", int'(res_valid), 1);
        $display("[TB] locked loads checked");

        // Back-to-back start from DONE without ack
        go();
        check_eq("b2b_valid_drop", int'(res_valid), 0);
        check_eq("b2b_sa_clr", int'(sa_clr), 1);
        wait_done(nb, nc);
        check_eq("b2b_busy_len", nb, BUSY_LEN);
        check_eq("b2b_clr_pulses", nc, 1);
        check_product("b2b");
        check_eq("b2b_c03", c_dut[0][3], 33);
        ack();

        // Async abort at step 10
        go();
        wait_step(11);
        #1 rst_n = 1'b0;
        #1;
        check_eq("abort_outputs", int'({ld_rej, busy, res_valid, sa_clr}), 0);
        check_vec("abort_feeds", a_feed | b_feed, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                ld(1'b0, r, c, 2);
                ld(1'b1, r, c, 3);
            end
        go();
        wait_done(nb, nc);
        check_product("abort");
        bad = 0;
        for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) if (c_dut[i][j] != 48) bad++;
        check_eq("abort_c48", bad, 0);
        ack();
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
